cpu2: RTL and testbench
=======================

# cpu2

Minimal 8-bit multicycle CPU with 16 bytes of unified instruction/data memory. It fetches 8-bit instructions (4-bit opcode, 4-bit direct address) and executes accumulator and read-modify-write memory operations. It drives an external memory through separate read/write strobes, a 4-bit address and split 8-bit data buses. It is the processor core of the small RISC system and sits between the clock/reset source and the 16×8 memory array.

## Interface
- No parameters. Data width 8, address width 4, fixed.
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `read` out 1: memory read strobe. High in FETCH and EXEC.
- `write` out 1: memory write strobe. Memory captures `memoryIn` at `address` on the rising edge while high.
- `memoryOut` in 8: memory read data. Combinational `M[address]`.
- `memoryIn` out 8: write data to memory.
- `address` out 4: memory address.

## Operation
- Instruction format: `[7:4]` opcode, `[3:0]` operand address `a`.
- Opcodes:
  - 0000 NOP
  - 0001 LOAD: A←M[a]
  - 0010 STORE: M[a]←A
  - 0011 ADD: A←A+M[a] (mod 256)
  - 0100 SUB: A←A−M[a] (mod 256)
  - 0101 INC: M[a]←M[a]+1 (mod 256)
  - 0110 COM: M[a]←~M[a]
  - 0111 JMP: PC←a
  - 1000 JZ: if A==0, PC←a
  - 1001–1110: NOP
  - 1111: HALT
- Registers:
  - PC: 4 bits. Increments mod 16, so 15 wraps to 0.
  - IR: 8 bits.
  - A: 8-bit accumulator.
  - D: 8-bit write-data register.
- No flags. JZ tests A directly.
- FSM states: FETCH, EXEC, WRITE, HALT.
  - FETCH: address=PC, read=1. At the edge, IR←memoryOut and PC←PC+1. Next state is EXEC.
  - EXEC: address=IR[3:0], read=1. At the edge:
    - LOAD, ADD, SUB update A.
    - JMP and JZ (when taken) load PC.
    - INC and COM load D←f(memoryOut).
    - STORE loads D←A.
    - Next state is WRITE for INC, COM, STORE; HALT for opcode 1111; FETCH otherwise.
  - WRITE: address=IR[3:0], write=1, memoryIn=D. Next state is FETCH.
  - HALT: read=0, write=0, address=PC. The core stays in HALT until reset.
- `memoryIn` equals D in every state. It is only meaningful when `write` is high.
- `read` and `write` are never high together.

## Timing
- Reset asserted (low):
  - state=FETCH; PC, IR, A, D = 0.
  - Outputs forced to `read`=0, `write`=0, `address`=0, `memoryIn`=0.
- First rising edge after release fetches M[0].
- Cycles per instruction:
  - 2 cycles: NOP, LOAD, ADD, SUB, JMP, JZ.
  - 3 cycles: STORE, INC, COM.
  - HALT enters the HALT state after 2 cycles.
- Outputs are decoded combinationally from state and registers (Moore).
- Reset asserted mid-instruction aborts the instruction immediately; a pending WRITE is not performed.
- A taken JMP/JZ overrides the FETCH increment. The next fetch is from `a`.
- Self-modifying code is allowed. A write to M[PC] takes effect on the next fetch.

## Structure
- Shared package `cpu2_pkg` holds:
  - opcode localparams (`OP_NOP`…`OP_HALT`)
  - state enum (`S_FETCH`, `S_EXEC`, `S_WRITE`, `S_HALT`)
  - width constants (`DW`=8, `AW`=4)
- One natural sub-module, `cpu2_alu`. It is combinational, takes opcode, A and operand, and returns the 8-bit result for ADD/SUB/INC/COM/LOAD/STORE.
- The FSM and registers live in the top level.

## Test plan
- Two's complement: M0=0x66, M1=0x56, M2=0x54, M3–M5=0, M6=0x03, reset → M6=0xFC after cycle 3, 0xFD after cycle 6, M4=0x01 after cycle 9.
- Accumulator: LOAD 8 / ADD 9 / STORE 10 / HALT with M8=0xF0, M9=0x20 → M10=0x10. Afterwards `read`=`write`=0 permanently.
- Branches:
  - JZ with A=0 → PC=a.
  - JZ with A=0x01 → falls through.
  - JMP 0 loops. Verify fetch addresses.
- PC wrap: all-NOP memory → fetch addresses 0,1,…,15,0. No writes ever.
- Reset mid-WRITE: pull reset low during the WRITE of COM → memory unchanged; `read`/`write`/`address`=0 while low; after release, fetch from 0.
- SUB underflow: A=0x00, SUB with M=0x01 → A=0xFF. INC of 0xFF → 0x00.

Source files
------------

// File: rtl/cpu2_pkg.sv
// cpu2_pkg: shared definitions for the cpu2 multicycle core.
//   DW/AW      : data and address widths
//   OP_*       : 4-bit opcodes carried in IR[7:4]
//   state_t    : control FSM states
package cpu2_pkg;

  localparam int DW = 8;
  localparam int AW = 4;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_INC   = 4'h5;
  localparam logic [3:0] OP_COM   = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_WRITE,
    S_HALT
  } state_t;

endpackage

// File: rtl/cpu2_alu.sv
// cpu2_alu: combinational datapath for the cpu2 core.
//   op      in  4 : opcode from IR[7:4]
//   acc     in  8 : accumulator A
//   operand in  8 : memory read data M[a]
//   result  out 8 : new A (LOAD/ADD/SUB) or new D (STORE/INC/COM)
module cpu2_alu
  import cpu2_pkg::*;
(
  input  logic [3:0]    op,
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] operand,
  output logic [DW-1:0] result
);

  always_comb begin
    result = acc;
    case (op)
      OP_LOAD:  result = operand;
      OP_STORE: result = acc;
      OP_ADD:   result = acc + operand;
      OP_SUB:   result = acc - operand;
      OP_INC:   result = operand + 8'd1;
      OP_COM:   result = ~operand;
      default:  result = acc;
    endcase
  end

endmodule

// File: rtl/cpu2.sv
// cpu2: minimal 8-bit multicycle accumulator CPU driving a 16x8 unified memory.
//   clk       in  1 : clock, rising edge
//   reset     in  1 : asynchronous active-low reset
//   read      out 1 : read strobe (FETCH, EXEC)
//   write     out 1 : write strobe (WRITE)
//   memoryOut in  8 : combinational M[address]
//   memoryIn  out 8 : write data (always D)
//   address   out 4 : memory address
module cpu2
  import cpu2_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  output logic          read,
  output logic          write,
  input  logic [DW-1:0] memoryOut,
  output logic [DW-1:0] memoryIn,
  output logic [AW-1:0] address
);

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] ir_q;
  logic [DW-1:0] acc_q;
  logic [DW-1:0] d_q;
  logic [DW-1:0] alu_res;

  cpu2_alu u_alu (
    .op      (ir_q[7:4]),
    .acc     (acc_q),
    .operand (memoryOut),
    .result  (alu_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      d_q     <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          ir_q    <= memoryOut;
          pc_q    <= pc_q + 4'd1;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          state_q <= S_FETCH;
          case (ir_q[7:4])
            OP_LOAD, OP_ADD, OP_SUB: acc_q <= alu_res;
            OP_STORE, OP_INC, OP_COM: begin
              d_q     <= alu_res;
              state_q <= S_WRITE;
            end
            OP_JMP: pc_q <= ir_q[3:0];
            OP_JZ: begin
              if (acc_q == '0) pc_q <= ir_q[3:0];
            end
            OP_HALT: state_q <= S_HALT;
            default: ;
          endcase
        end
        S_WRITE: state_q <= S_FETCH;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Strobes are gated by reset so an aborted WRITE never reaches memory.
  always_comb begin
    read    = 1'b0;
    write   = 1'b0;
    address = '0;
    if (reset) begin
      unique case (state_q)
        S_FETCH: begin
          read    = 1'b1;
          address = pc_q;
        end
        S_EXEC: begin
          read    = 1'b1;
          address = ir_q[3:0];
        end
        S_WRITE: begin
          write   = 1'b1;
          address = ir_q[3:0];
        end
        S_HALT: address = pc_q;
        default: ;
      endcase
    end
  end

  assign memoryIn = d_q;

endmodule

// File: tb/tb_cpu2.sv
module tb_cpu2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       read, write;
  logic [7:0] memoryOut, memoryIn;
  logic [3:0] address;

  logic [7:0] mem [16];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  cpu2 dut (
    .clk       (clk),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .memoryOut (memoryOut),
    .memoryIn  (memoryIn),
    .address   (address)
  );

  always #5 clk = ~clk;

  assign memoryOut = mem[address];

  always @(posedge clk) if (write) mem[address] <= memoryIn;

  // ISA-level reference: each executed instruction expands into its expected bus cycles.
  typedef struct {
    logic       rd;
    logic       wr;
    logic [3:0] ad;
    logic [7:0] d;
  } ent_t;

  ent_t       q[$];
  logic [7:0] mm [16];
  logic [3:0] mpc;
  logic [7:0] ma, md;
  bit         mhalt;

  task automatic model_init();
    mpc = 4'd0;
    ma = 8'd0;
    md = 8'd0;
    mhalt = 1'b0;
    q.delete();
    for (int i = 0; i < 16; i++) mm[i] = mem[i];
  endtask

  task automatic model_step();
    logic [7:0] ins, v;
    logic [3:0] a;
    if (mhalt) begin
      q.push_back('{1'b0, 1'b0, mpc, md});
    end else begin
      ins = mm[mpc];
      q.push_back('{1'b1, 1'b0, mpc, md});
      mpc = mpc + 4'd1;
      a = ins[3:0];
      q.push_back('{1'b1, 1'b0, a, md});
      v = mm[a];
      case (ins[7:4])
        4'd1: ma = v;
        4'd2: begin md = ma; mm[a] = md; q.push_back('{1'b0, 1'b1, a, md}); end
        4'd3: ma = ma + v;
        4'd4: ma = ma - v;
        4'd5: begin md = v + 8'd1; mm[a] = md; q.push_back('{1'b0, 1'b1, a, md}); end
        4'd6: begin md = ~v; mm[a] = md; q.push_back('{1'b0, 1'b1, a, md}); end
        4'd7: mpc = a;
        4'd8: if (ma == 8'd0) mpc = a;
        4'd15: mhalt = 1'b1;
        default: ;
      endcase
    end
  endtask

  // Per-cycle bus comparison against the model.
  always @(negedge clk) begin
    ent_t e;
    if (chk_en) begin
      if (q.size() == 0) model_step();
      e = q.pop_front();
      checks++;
      if ({read, write, address, memoryIn} !== {e.rd, e.wr, e.ad, e.d}) begin
        failures++;
        $display("FAIL bus cycle %0d: got rd=%b wr=%b addr=%h din=%h, want rd=%b wr=%b addr=%h din=%h",
                 cyc, read, write, address, memoryIn, e.rd, e.wr, e.ad, e.d);
      end
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic load_clear();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  task automatic start_run(input int n);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {1'b0, read, write, address, memoryIn[0]}, 8'h00);
    chk("reset memoryIn", memoryIn, 8'h00);
    model_init();
    cyc = 0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    chk_en = 1'b1;
    repeat (n) @(negedge clk);
    #1;
    chk_en = 1'b0;
  endtask

  task automatic continue_run(input int n);
    chk_en = 1'b1;
    repeat (n) @(negedge clk);
    #1;
    chk_en = 1'b0;
  endtask

  initial begin
    // Two's complement: COM 6, INC 6, INC 4.
    load_clear();
    mem[0] = 8'h66; mem[1] = 8'h56; mem[2] = 8'h54; mem[6] = 8'h03;
    start_run(4);
    chk("twos M6 after cycle 3", mem[6], 8'hFC);
    continue_run(6);
    chk("twos M6 after cycle 6", mem[6], 8'hFD);
    chk("twos M4 after cycle 9", mem[4], 8'h01);

    // Accumulator: LOAD 8, ADD 9, STORE 10, HALT.
    load_clear();
    mem[0] = 8'h18; mem[1] = 8'h39; mem[2] = 8'h2A; mem[3] = 8'hF0;
    mem[8] = 8'hF0; mem[9] = 8'h20;
    start_run(20);
    chk("acc M10", mem[10], 8'h10);
    chk("halt strobes", {6'd0, read, write}, 8'h00);

    // Branches: JZ taken, LOAD 1, JZ not taken, JMP 0.
    load_clear();
    mem[0] = 8'h84; mem[4] = 8'h1E; mem[5] = 8'h88; mem[6] = 8'h70;
    mem[8] = 8'hF0; mem[14] = 8'h01;
    start_run(2);
    continue_run(1);
    chk("jz taken fetch addr", {4'd0, address}, 8'h04);
    continue_run(4);
    chk("jz fallthrough fetch addr", {4'd0, address}, 8'h06);
    continue_run(2);
    chk("jmp 0 fetch addr", {4'd0, address}, 8'h00);
    continue_run(30);

    // PC wrap on all-NOP memory.
    load_clear();
    start_run(31);
    chk("wrap fetch 15", {3'd0, read, address}, 8'h1F);
    continue_run(2);
    chk("wrap fetch 0", {3'd0, read, address}, 8'h10);
    continue_run(8);

    // Reset during the WRITE cycle of COM 15.
    load_clear();
    mem[0] = 8'h6F; mem[15] = 8'h5A;
    start_run(3);
    chk("in write cycle", {7'd0, write}, 8'h01);
    reset = 1'b0;
    #1;
    chk("reset mid-write strobes", {3'd0, read, write, 3'd0}, 8'h00);
    chk("reset mid-write addr", {4'd0, address}, 8'h00);
    @(posedge clk);
    #1;
    chk("aborted write M15", mem[15], 8'h5A);
    start_run(6);
    chk("rerun COM M15", mem[15], 8'hA5);

    // SUB underflow and INC wrap.
    load_clear();
    mem[0] = 8'h4E; mem[1] = 8'h2D; mem[2] = 8'h5D; mem[3] = 8'h2C; mem[4] = 8'hF0;
    mem[12] = 8'h77; mem[13] = 8'h33; mem[14] = 8'h01;
    start_run(20);
    chk("sub underflow M12", mem[12], 8'hFF);
    chk("inc wrap M13", mem[13], 8'h00);

    // Random programs.
    for (int p = 0; p < 8; p++) begin
      bit same;
      load_clear();
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      start_run(150);
      for (int k = 0; k < 4 && q.size() != 0; k++) continue_run(1);
      @(posedge clk);
      #1;
      same = 1'b1;
      for (int i = 0; i < 16; i++) if (mem[i] !== mm[i]) same = 1'b0;
      checks++;
      if (!same) begin
        failures++;
        $display("FAIL random program %0d memory image: got M0=%h M15=%h want M0=%h M15=%h",
                 p, mem[0], mem[15], mm[0], mm[15]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
